mc_ctrl: RTL and testbench

- Multi-cycle main controller for the MIPS datapath.
- Sequences each instruction through the fetch, decode, execute, memory and writeback steps.
- Drives the select lines consumed by the datapath muxes: RegDst, ALUSrc and MemtoReg.
- Also drives the per-state write enables, extender mode, ALU op and next-PC op.
- Sits between the IR opcode/funct fields and the datapath, replacing the single-cycle combinational decoder.

---
 rtl/ctrl_defs.sv | 70 +++++++
 rtl/mc_decode.sv | 37 +++
 rtl/mc_ctrl.sv | 140 ++++++++++++++
 tb/tb_mc_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ctrl_defs.sv
// ctrl_defs: shared definitions for the multi-cycle MIPS controller.
//   - FSM state encodings
//   - opcode / funct constants for the supported instructions
//   - mux select encodings shared with the datapath (RegDst, MemtoReg,
//     ExtOp, ALUOp, NPCOp)
//   - instruction-class struct produced by mc_decode
package ctrl_defs;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    localparam logic [1:0] MR_ALU   = 2'b00;
    localparam logic [1:0] MR_MEM   = 2'b01;
    localparam logic [1:0] MR_LINK  = 2'b10;
    localparam logic [1:0] MR_SLT   = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    // One-hot-ish instruction class. is_r covers the ALU R-types
    // (addu/subu/slt); jr is R-format but is classed on its own.
    typedef struct packed {
        logic is_r;
        logic is_subu;
        logic is_slt;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_j;
        logic is_jal;
        logic is_jr;
        logic is_ori;
        logic is_lui;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct to instruction-class decode.
// Ports:
//   opcode - IR[31:26]
//   funct  - IR[5:0], only meaningful for opcode 000000
//   cls    - instruction class flags; illegal set for anything unsupported
module mc_decode
    import ctrl_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    cls
);

    always_comb begin
        cls = '0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADDU: cls.is_r = 1'b1;
                    FN_SUBU: begin cls.is_r = 1'b1; cls.is_subu = 1'b1; end
                    FN_SLT:  begin cls.is_r = 1'b1; cls.is_slt  = 1'b1; end
                    FN_JR:   cls.is_jr = 1'b1;
                    default: cls.illegal = 1'b1;
                endcase
            end
            OP_ORI:  cls.is_ori = 1'b1;
            OP_LW:   cls.is_lw  = 1'b1;
            OP_SW:   cls.is_sw  = 1'b1;
            OP_BEQ:  cls.is_beq = 1'b1;
            OP_LUI:  cls.is_lui = 1'b1;
            OP_J:    cls.is_j   = 1'b1;
            OP_JAL:  cls.is_jal = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS datapath.
// The state register is the only flop; every output is a combinational
// decode of state/opcode/funct/zero.
// Ports:
//   clk, reset          - clock (rising edge), async active-high reset
//   opcode, funct, zero - IR fields and ALU equality flag
//   state               - current FSM state (debug)
//   PCWr/IRWr/RegWr/MemWr - write enables, forced low during reset
//   RegDst/ALUSrc/MemtoReg/ExtOp/ALUOp/NPCOp - datapath selects
module mc_ctrl
    import ctrl_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] state,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [1:0] RegDst,
    output logic       ALUSrc,
    output logic [1:0] MemtoReg,
    output logic [1:0] ExtOp,
    output logic [2:0] ALUOp,
    output logic [1:0] NPCOp
);

    iclass_t cls;
    state_t  state_q, state_n;
    logic    pcwr, irwr, regwr, memwr;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_n;
    end

    // next state
    always_comb begin
        state_n = S_IF;
        unique case (state_q)
            S_IF:  state_n = S_ID;
            S_ID:  state_n = (cls.is_j || cls.is_jal || cls.is_jr || cls.illegal)
                             ? S_IF : S_EXE;
            S_EXE: begin
                if (cls.is_beq)                state_n = S_IF;
                else if (cls.is_lw || cls.is_sw) state_n = S_MEM;
                else                           state_n = S_WB;
            end
            S_MEM: state_n = cls.is_lw ? S_WB : S_IF;
            S_WB:  state_n = S_IF;
            default: state_n = S_IF;
        endcase
    end

    // output decode
    always_comb begin
        pcwr     = 1'b0;
        irwr     = 1'b0;
        regwr    = 1'b0;
        memwr    = 1'b0;
        RegDst   = RD_RT;
        ALUSrc   = 1'b0;
        MemtoReg = MR_ALU;
        ExtOp    = EXT_ZERO;
        ALUOp    = ALU_ADD;
        NPCOp    = NPC_PC4;

        // ALU operand/op selects are driven from EXE through WB so the
        // address/result the MEM and WB writes consume never glitches.
        if (state_q inside {S_EXE, S_MEM, S_WB}) begin
            if (cls.is_r) begin
                ALUOp = (cls.is_subu || cls.is_slt) ? ALU_SUB : ALU_ADD;
            end else if (cls.is_ori) begin
                ALUSrc = 1'b1; ExtOp = EXT_ZERO; ALUOp = ALU_OR;
            end else if (cls.is_lui) begin
                ALUSrc = 1'b1; ExtOp = EXT_LUI;  ALUOp = ALU_ADD;
            end else if (cls.is_lw || cls.is_sw) begin
                ALUSrc = 1'b1; ExtOp = EXT_SIGN; ALUOp = ALU_ADD;
            end else if (cls.is_beq) begin
                ALUOp = ALU_SUB;
            end
        end

        unique case (state_q)
            S_IF: begin
                irwr = 1'b1;
                pcwr = 1'b1;
            end
            S_ID: begin
                if (cls.is_j) begin
                    pcwr = 1'b1; NPCOp = NPC_JMP;
                end else if (cls.is_jal) begin
                    pcwr = 1'b1; NPCOp = NPC_JMP;
                    regwr = 1'b1; RegDst = RD_RA; MemtoReg = MR_LINK;
                end else if (cls.is_jr) begin
                    pcwr = 1'b1; NPCOp = NPC_JR;
                end
            end
            S_EXE: begin
                if (cls.is_beq) begin
                    NPCOp = NPC_BR;
                    pcwr  = zero;
                end
            end
            S_MEM: begin
                if (cls.is_sw) memwr = 1'b1;
            end
            S_WB: begin
                if (cls.is_r) begin
                    regwr = 1'b1; RegDst = RD_RD;
                    MemtoReg = cls.is_slt ? MR_SLT : MR_ALU;
                end else if (cls.is_ori || cls.is_lui) begin
                    regwr = 1'b1; RegDst = RD_RT; MemtoReg = MR_ALU;
                end else if (cls.is_lw) begin
                    regwr = 1'b1; RegDst = RD_RT; MemtoReg = MR_MEM;
                end
            end
            default: ;  // encodings 5-7: everything stays low
        endcase
    end

    // Enables are squashed for the whole time reset is high, including
    // the IF decode the async reset forces the state into.
    assign PCWr  = pcwr  & ~reset;
    assign IRWr  = irwr  & ~reset;
    assign RegWr = regwr & ~reset;
    assign MemWr = memwr & ~reset;
    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic [2:0] state;
    logic       PCWr, IRWr, RegWr, MemWr, ALUSrc;
    logic [1:0] RegDst, MemtoReg, ExtOp, NPCOp;
    logic [2:0] ALUOp;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .state(state), .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .ExtOp(ExtOp),
        .ALUOp(ALUOp), .NPCOp(NPCOp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pc, ir, rw, mw;
        logic [1:0] rd;
        logic       as;
        logic [1:0] mr, ex;
        logic [2:0] ao;
        logic [1:0] np;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    localparam logic [5:0] R = 6'b000000;

    function automatic exp_t e(input logic [2:0] st, input logic pc, input logic ir,
                               input logic rw, input logic mw, input logic [1:0] rd,
                               input logic as, input logic [1:0] mr, input logic [1:0] ex,
                               input logic [2:0] ao, input logic [1:0] np);
        exp_t x;
        x = '{st, pc, ir, rw, mw, rd, as, mr, ex, ao, np};
        return x;
    endfunction

    // one cycle of stimulus; expected response goes to the scoreboard
    task automatic cyc(input string nm, input logic rst, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, input exp_t x);
        @(posedge clk);
        #1;
        reset  = rst;
        opcode = op;
        funct  = fn;
        zero   = z;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // monitor: outputs are combinational and valid every cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  w;
            exp_t  g;
            string n;
            w = exp_q.pop_front();
            n = name_q.pop_front();
            g = '{state, PCWr, IRWr, RegWr, MemWr, RegDst, ALUSrc, MemtoReg, ExtOp, ALUOp, NPCOp};
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL %s: got st=%0d pc=%b ir=%b rw=%b mw=%b rd=%b as=%b mr=%b ex=%b ao=%b np=%b want st=%0d pc=%b ir=%b rw=%b mw=%b rd=%b as=%b mr=%b ex=%b ao=%b np=%b",
                         n, g.st, g.pc, g.ir, g.rw, g.mw, g.rd, g.as, g.mr, g.ex, g.ao, g.np,
                         w.st, w.pc, w.ir, w.rw, w.mw, w.rd, w.as, w.mr, w.ex, w.ao, w.np);
            end
        end
    end

    initial begin
        //                                  st pc ir rw mw rd   as mr   ex   ao     np
        cyc("reset",      1, R, 6'h21, 0, e(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        // addu interrupted by reset in EXE
        cyc("addu_if",    0, R, 6'h21, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("addu_id",    0, R, 6'h21, 0, e(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("addu_exe",   0, R, 6'h21, 0, e(2, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("midrst",     1, R, 6'h21, 0, e(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("addu_if2",   0, R, 6'h21, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("addu_id2",   0, R, 6'h21, 0, e(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("addu_exe2",  0, R, 6'h21, 0, e(2, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("addu_wb",    0, R, 6'h21, 0, e(4, 0, 0, 1, 0, 2'd1, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        // lw
        cyc("lw_if",      0, 6'b100011, 0, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("lw_id",      0, 6'b100011, 0, 0, e(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("lw_exe",     0, 6'b100011, 0, 0, e(2, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd1, 3'd0, 2'd0));
        cyc("lw_mem",     0, 6'b100011, 0, 0, e(3, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd1, 3'd0, 2'd0));
        cyc("lw_wb",      0, 6'b100011, 0, 0, e(4, 0, 0, 1, 0, 2'd0, 1, 2'd1, 2'd1, 3'd0, 2'd0));
        // sw
        cyc("sw_if",      0, 6'b101011, 0, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("sw_id",      0, 6'b101011, 0, 0, e(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("sw_exe",     0, 6'b101011, 0, 0, e(2, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd1, 3'd0, 2'd0));
        cyc("sw_mem",     0, 6'b101011, 0, 0, e(3, 0, 0, 0, 1, 2'd0, 1, 2'd0, 2'd1, 3'd0, 2'd0));
        // beq taken
        cyc("beq1_if",    0, 6'b000100, 0, 1, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("beq1_id",    0, 6'b000100, 0, 1, e(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("beq1_exe",   0, 6'b000100, 0, 1, e(2, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd1, 2'd1));
        // beq not taken
        cyc("beq0_if",    0, 6'b000100, 0, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("beq0_id",    0, 6'b000100, 0, 0, e(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("beq0_exe",   0, 6'b000100, 0, 0, e(2, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd1, 2'd1));
        // jal
        cyc("jal_if",     0, 6'b000011, 0, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("jal_id",     0, 6'b000011, 0, 0, e(1, 1, 0, 1, 0, 2'd2, 0, 2'd2, 2'd0, 3'd0, 2'd2));
        // slt
        cyc("slt_if",     0, R, 6'b101010, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("slt_id",     0, R, 6'b101010, 0, e(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("slt_exe",    0, R, 6'b101010, 0, e(2, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd1, 2'd0));
        cyc("slt_wb",     0, R, 6'b101010, 0, e(4, 0, 0, 1, 0, 2'd1, 0, 2'd3, 2'd0, 3'd1, 2'd0));
        // undefined opcode runs as a nop
        cyc("undef_if",   0, 6'b111111, 0, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("undef_id",   0, 6'b111111, 0, 0, e(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        // j
        cyc("j_if",       0, 6'b000010, 0, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("j_id",       0, 6'b000010, 0, 0, e(1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd2));
        // jr
        cyc("jr_if",      0, R, 6'b001000, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("jr_id",      0, R, 6'b001000, 0, e(1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd3));
        // ori
        cyc("ori_if",     0, 6'b001101, 0, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("ori_id",     0, 6'b001101, 0, 0, e(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("ori_exe",    0, 6'b001101, 0, 0, e(2, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 3'd2, 2'd0));
        cyc("ori_wb",     0, 6'b001101, 0, 0, e(4, 0, 0, 1, 0, 2'd0, 1, 2'd0, 2'd0, 3'd2, 2'd0));
        // lui
        cyc("lui_if",     0, 6'b001111, 0, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("lui_id",     0, 6'b001111, 0, 0, e(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("lui_exe",    0, 6'b001111, 0, 0, e(2, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd2, 3'd0, 2'd0));
        cyc("lui_wb",     0, 6'b001111, 0, 0, e(4, 0, 0, 1, 0, 2'd0, 1, 2'd0, 2'd2, 3'd0, 2'd0));
        // subu
        cyc("subu_if",    0, R, 6'b100011, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("subu_id",    0, R, 6'b100011, 0, e(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));
        cyc("subu_exe",   0, R, 6'b100011, 0, e(2, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd1, 2'd0));
        cyc("subu_wb",    0, R, 6'b100011, 0, e(4, 0, 0, 1, 0, 2'd1, 0, 2'd0, 2'd0, 3'd1, 2'd0));
        cyc("final_if",   0, R, 6'b100001, 0, e(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 3'd0, 2'd0));

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
